mem_arbiter: RTL

Two-requester arbiter that shares the single data-memory port between the CPU load/store path and the DMA engine. It sits between those two masters and the data RAM, and owns all arbitration decisions. A grant is locked for the full length of each transaction, so address and data stay stable across multi-cycle memory responses. CPU has default priority, and bounded-fairness counters prevent either side from starving the other.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (CPU / DMA) arbiter for the single data-RAM port.
//            Grants are locked until the RAM completes. CPU has default
//            priority; streak/burst counters give DMA a bounded turn.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int CPU_STREAK_MAX = 4,
  parameter int DMA_BURST_MAX  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_req,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [XLEN-1:0]   cpu_mem_wdata,
  output logic              cpu_mem_ready,
  output logic [XLEN-1:0]   cpu_mem_rdata,
  input  logic              dma_mem_req,
  input  logic              dma_mem_we,
  input  logic [ADDR_W-1:0] dma_mem_addr,
  input  logic [XLEN-1:0]   dma_mem_wdata,
  output logic              dma_mem_ready,
  output logic [XLEN-1:0]   dma_mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              dma_owner
);

  localparam int c_streak_w = $clog2(CPU_STREAK_MAX + 1);
  localparam int c_cnt_w    = $clog2(DMA_BURST_MAX + 1);
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(CPU_STREAK_MAX);
  localparam logic [c_cnt_w-1:0]    c_burst_max  = c_cnt_w'(DMA_BURST_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  owner_t                r_owner, w_owner_n, w_sel;
  logic [c_streak_w-1:0] r_cpu_streak, w_cpu_streak_n, w_streak_inc;
  logic                  r_dma_turn, w_dma_turn_n;
  logic [c_cnt_w-1:0]    r_dma_cnt, w_dma_cnt_n, w_cnt_inc;
  logic                  w_done;

  // Selection: a locked owner keeps the port while it holds req; otherwise
  // arbitrate. Reset forces no selection so nothing leaks out while held.
  always_comb begin
    w_sel = OWN_NONE;
    if (!rst_n) begin
      w_sel = OWN_NONE;
    end else if (r_owner == OWN_CPU) begin
      w_sel = cpu_mem_req ? OWN_CPU : OWN_NONE;
    end else if (r_owner == OWN_DMA) begin
      w_sel = dma_mem_req ? OWN_DMA : OWN_NONE;
    end else if (cpu_mem_req && dma_mem_req) begin
      w_sel = r_dma_turn ? OWN_DMA : OWN_CPU;
    end else if (cpu_mem_req) begin
      w_sel = OWN_CPU;
    end else if (dma_mem_req) begin
      w_sel = OWN_DMA;
    end
  end

  // Request/response steering between the selected master and the RAM.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cpu_mem_ready = 1'b0;
    cpu_mem_rdata = '0;
    dma_mem_ready = 1'b0;
    dma_mem_rdata = '0;
    dma_owner     = 1'b0;
    if (w_sel == OWN_CPU) begin
      mem_req       = 1'b1;
      mem_we        = cpu_mem_we;
      mem_addr      = cpu_mem_addr;
      mem_wdata     = cpu_mem_wdata;
      cpu_mem_ready = mem_ready;
      cpu_mem_rdata = mem_ready ? mem_rdata : '0;
    end else if (w_sel == OWN_DMA) begin
      mem_req       = 1'b1;
      mem_we        = dma_mem_we;
      mem_addr      = dma_mem_addr;
      mem_wdata     = dma_mem_wdata;
      dma_mem_ready = mem_ready;
      dma_mem_rdata = mem_ready ? mem_rdata : '0;
      dma_owner     = 1'b1;
    end
  end

  assign w_done       = mem_ready && (w_sel != OWN_NONE);
  assign w_streak_inc = (r_cpu_streak == c_streak_max) ? r_cpu_streak
                                                       : r_cpu_streak + 1'b1;
  assign w_cnt_inc    = r_dma_cnt + 1'b1;

  // Next owner (lock until completion) and fairness bookkeeping.
  always_comb begin
    w_owner_n      = OWN_NONE;
    w_cpu_streak_n = r_cpu_streak;
    w_dma_turn_n   = r_dma_turn;
    w_dma_cnt_n    = r_dma_cnt;

    if ((w_sel != OWN_NONE) && !mem_ready) begin
      w_owner_n = w_sel;
    end

    if (w_done && (w_sel == OWN_CPU)) begin
      if (dma_mem_req) begin
        if (w_streak_inc >= c_streak_max) begin
          w_dma_turn_n   = 1'b1;
          w_dma_cnt_n    = '0;
          w_cpu_streak_n = '0;
        end else begin
          w_cpu_streak_n = w_streak_inc;
        end
      end else begin
        w_cpu_streak_n = '0;
      end
    end else if (w_done && (w_sel == OWN_DMA)) begin
      w_cpu_streak_n = '0;
      if (r_dma_turn) begin
        if (w_cnt_inc >= c_burst_max) begin
          w_dma_turn_n = 1'b0;
          w_dma_cnt_n  = '0;
        end else begin
          w_dma_cnt_n = w_cnt_inc;
        end
      end
    end

    // DMA gone quiet while the port is idle: its turn is forfeited.
    if ((r_owner == OWN_NONE) && !dma_mem_req) begin
      w_dma_turn_n = 1'b0;
      w_dma_cnt_n  = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWN_NONE;
      r_cpu_streak <= '0;
      r_dma_turn   <= 1'b0;
      r_dma_cnt    <= '0;
    end else begin
      r_owner      <= w_owner_n;
      r_cpu_streak <= w_cpu_streak_n;
      r_dma_turn   <= w_dma_turn_n;
      r_dma_cnt    <= w_dma_cnt_n;
    end
  end

endmodule
`default_nettype wire
